i2c_eeprom_master: RTL and testbench

- Byte-level I2C master engine for AT24C02-class EEPROMs.
- Sits directly downstream of the AXI4-Lite register interface. It consumes the latched control/address/data fields and the one-cycle start strobe.
- Runs a complete byte-write or random-read transaction on SCL/SDA.
- Returns real busy/done/ack-error status and read data, replacing the fixed-count busy approximation.

---
 rtl/i2c_eeprom_master.sv | 194 +++++++++++++++++++
 tb/tb_i2c_eeprom_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_master.sv
// Byte-level I2C master for AT24C02-class EEPROMs: one byte write or one random read
// per start strobe, with busy/done/ack_err status and read-data capture.
module i2c_eeprom_master #(
    parameter int QTR_CNT = 62
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] mem_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP, DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  qcnt_reg;
    logic [1:0]  phase_reg;
    logic [2:0]  bit_reg;
    logic [1:0]  byte_reg;
    logic        rw_reg;
    logic [6:0]  dev_reg;
    logic [7:0]  mem_reg, wdata_reg, tx_reg, rx_reg;
    logic        ack_reg;
    logic        sda_meta, sda_sync;
    logic        scl_next, sda_oe_next;
    logic        qtr_end, slot_end, sample;

    assign qtr_end  = (qcnt_reg == 8'(QTR_CNT - 1));
    assign slot_end = qtr_end && (phase_reg == 2'd3);
    assign sample   = qtr_end && (phase_reg == 2'd2);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = START;
            START:   if (slot_end) state_next = TX_BYTE;
            TX_BYTE: if (slot_end && bit_reg == 3'd7) state_next = RX_ACK;
            RX_ACK: begin
                if (slot_end) begin
                    if (ack_reg)               state_next = STOP;
                    else if (byte_reg == 2'd0) state_next = TX_BYTE;
                    else if (byte_reg == 2'd1) state_next = rw_reg ? RSTART : TX_BYTE;
                    else                       state_next = rw_reg ? RX_BYTE : STOP;
                end
            end
            RSTART:  if (slot_end) state_next = TX_BYTE;
            RX_BYTE: if (slot_end && bit_reg == 3'd7) state_next = TX_NACK;
            TX_NACK: if (slot_end) state_next = STOP;
            STOP:    if (slot_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Line levels decoded from the current slot phase; registered, so the pins
    // trail the phase counter by one cycle uniformly across all slot types.
    always_comb begin
        scl_next    = 1'b1;
        sda_oe_next = 1'b0;
        case (state_reg)
            START: begin
                scl_next    = (phase_reg != 2'd3);
                sda_oe_next = phase_reg[1];
            end
            TX_BYTE: begin
                scl_next    = phase_reg[1];
                sda_oe_next = ~tx_reg[7];
            end
            RX_ACK, RX_BYTE, TX_NACK: scl_next = phase_reg[1];
            RSTART: begin
                scl_next    = (phase_reg == 2'd1) || (phase_reg == 2'd2);
                sda_oe_next = phase_reg[1];
            end
            STOP: begin
                scl_next    = (phase_reg != 2'd0);
                sda_oe_next = (phase_reg != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            qcnt_reg  <= '0;
            phase_reg <= '0;
            bit_reg   <= '0;
            byte_reg  <= '0;
            rw_reg    <= 1'b0;
            dev_reg   <= '0;
            mem_reg   <= '0;
            wdata_reg <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            ack_reg   <= 1'b0;
            sda_meta  <= 1'b1;
            sda_sync  <= 1'b1;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            scl       <= 1'b1;
            sda_oe    <= 1'b0;
        end else begin
            sda_meta <= sda_i;
            sda_sync <= sda_meta;
            done     <= 1'b0;
            scl      <= scl_next;
            sda_oe   <= sda_oe_next;

            if (state_reg == IDLE || state_reg == DONE) begin
                qcnt_reg  <= '0;
                phase_reg <= '0;
            end else if (qtr_end) begin
                qcnt_reg  <= '0;
                phase_reg <= phase_reg + 2'd1;
            end else begin
                qcnt_reg  <= qcnt_reg + 8'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rw_reg    <= rw;
                        dev_reg   <= dev_addr;
                        mem_reg   <= mem_addr;
                        wdata_reg <= wdata;
                        busy      <= 1'b1;
                        ack_err   <= 1'b0;
                    end
                end
                START: begin
                    if (slot_end) begin
                        tx_reg   <= {dev_reg, 1'b0};
                        bit_reg  <= '0;
                        byte_reg <= 2'd0;
                    end
                end
                TX_BYTE: begin
                    if (slot_end) begin
                        tx_reg  <= {tx_reg[6:0], 1'b0};
                        bit_reg <= bit_reg + 3'd1;
                    end
                end
                RX_ACK: begin
                    if (sample) ack_reg <= sda_sync;
                    if (slot_end) begin
                        if (ack_reg) begin
                            ack_err <= 1'b1;
                        end else if (byte_reg == 2'd0) begin
                            tx_reg   <= mem_reg;
                            byte_reg <= 2'd1;
                        end else if (byte_reg == 2'd1 && !rw_reg) begin
                            tx_reg   <= wdata_reg;
                            byte_reg <= 2'd2;
                        end
                    end
                end
                RSTART: begin
                    if (slot_end) begin
                        tx_reg   <= {dev_reg, 1'b1};
                        byte_reg <= 2'd2;
                    end
                end
                RX_BYTE: begin
                    if (sample)   rx_reg  <= {rx_reg[6:0], sda_sync};
                    if (slot_end) bit_reg <= bit_reg + 3'd1;
                end
                TX_NACK: if (slot_end) rdata <= rx_reg;
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Bench for i2c_eeprom_master: a behavioural I2C EEPROM watches the bus, logs the
// frame as tokens and answers reads; each transaction is checked against expectations.
module tb_i2c_eeprom_master;

    localparam int Q      = 4;
    localparam int SLOT   = 4 * Q;
    localparam int TOK_S  = 256;
    localparam int TOK_P  = 512;
    localparam int TOK_MA = 768;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] mem_addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl, sda_oe;
    logic       sda_i;
    logic       slave_pull = 1'b0;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    logic [7:0] eeprom  [256];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata = 8'h00;

    int         obs_q[$];
    logic       nack_first = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, cs, cd;
    int         bitpos = 0, byte_no = 0;
    logic [7:0] rx_byte = '0, tx_data = '0, ptr = '0;
    logic       tx_mode = 1'b0, acked = 1'b0, ack_seen = 1'b0;

    assign sda_i = ~(sda_oe | slave_pull);

    always #5 aclk = ~aclk;

    i2c_eeprom_master #(.QTR_CNT(Q)) dut (
        .aclk(aclk), .areset(areset), .start(start), .rw(rw),
        .dev_addr(dev_addr), .mem_addr(mem_addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
        .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    // EEPROM device model: decodes START/STOP and bits from bus levels only.
    always @(negedge aclk) begin
        cs = scl;
        cd = sda_i;
        if (areset) begin
            bitpos = 0; byte_no = 0; tx_mode = 1'b0; slave_pull = 1'b0;
        end else if (prev_scl && cs && prev_sda && !cd) begin
            obs_q.push_back(TOK_S);
            bitpos = 0; byte_no = 0; tx_mode = 1'b0; slave_pull = 1'b0;
        end else if (prev_scl && cs && !prev_sda && cd) begin
            obs_q.push_back(TOK_P);
            bitpos = 0; byte_no = 0; tx_mode = 1'b0; slave_pull = 1'b0;
        end else if (!prev_scl && cs) begin
            if (bitpos < 8) rx_byte = {rx_byte[6:0], cd};
            else if (bitpos == 8) ack_seen = cd;
            bitpos++;
        end else if (prev_scl && !cs) begin
            if (bitpos == 8) begin
                if (tx_mode) begin
                    slave_pull = 1'b0;
                end else begin
                    obs_q.push_back(int'(rx_byte));
                    acked = !(nack_first && byte_no == 0);
                    slave_pull = acked;
                end
            end else if (bitpos == 9) begin
                if (tx_mode) begin
                    obs_q.push_back(TOK_MA + int'(ack_seen));
                    tx_mode = 1'b0;
                    slave_pull = 1'b0;
                end else if (byte_no == 0 && acked && rx_byte[0]) begin
                    tx_mode = 1'b1;
                    tx_data = eeprom[ptr];
                    slave_pull = ~tx_data[7];
                end else begin
                    if (byte_no == 1 && acked) ptr = rx_byte;
                    else if (byte_no == 2 && acked) eeprom[ptr] = rx_byte;
                    slave_pull = 1'b0;
                end
                byte_no++;
                bitpos = 0;
            end else if (tx_mode && bitpos >= 1 && bitpos <= 7) begin
                slave_pull = ~tx_data[7 - bitpos];
            end
        end
        prev_scl = cs;
        prev_sda = cd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic t_rw, input logic [6:0] t_dev, input logic [7:0] t_mem,
                           input logic [7:0] t_wd, input logic t_nack, input int glitch,
                           input logic b2b);
        int exp_q[$];
        int cycles;
        int slots;
        exp_q.push_back(TOK_S);
        exp_q.push_back(int'({t_dev, 1'b0}));
        if (t_nack) begin
            exp_q.push_back(TOK_P);
            slots = 11;
        end else if (!t_rw) begin
            exp_q.push_back(int'(t_mem));
            exp_q.push_back(int'(t_wd));
            exp_q.push_back(TOK_P);
            slots = 29;
            ref_mem[t_mem] = t_wd;
        end else begin
            exp_q.push_back(int'(t_mem));
            exp_q.push_back(TOK_S);
            exp_q.push_back(int'({t_dev, 1'b1}));
            exp_q.push_back(TOK_MA + 1);
            exp_q.push_back(TOK_P);
            slots = 39;
            exp_rdata = ref_mem[t_mem];
        end

        if (!b2b) begin
            @(posedge aclk); #1;
            check("done_one_cycle", 32'(done), 32'd0);
        end
        nack_first = t_nack;
        obs_q.delete();
        rw = t_rw; dev_addr = t_dev; mem_addr = t_mem; wdata = t_wd; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        rw = 1'($urandom); dev_addr = 7'($urandom); mem_addr = 8'($urandom); wdata = 8'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        check("ack_err_cleared", 32'(ack_err), 32'd0);

        cycles = 0;
        while (!done && cycles < 3000) begin
            @(posedge aclk); #1;
            cycles++;
            start = (cycles == glitch);
        end
        start = 1'b0;
        check("latency", 32'(cycles), 32'(1 + slots * SLOT));
        check("busy_at_done", 32'(busy), 32'd0);
        check("ack_err", 32'(ack_err), 32'(t_nack));
        check("rdata", 32'(rdata), 32'(exp_rdata));
        check("token_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("token%0d", i), (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF,
                  32'(exp_q[i]));
        $display("txn %0d rw=%0d dev=%02h mem=%02h wd=%02h nack=%0d cycles=%0d rdata=%02h ack_err=%0d",
                 txn_no, t_rw, t_dev, t_mem, t_wd, t_nack, cycles, rdata, ack_err);
        txn_no++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            eeprom[i]  = v;
            ref_mem[i] = v;
        end
        eeprom[8'h34]  = 8'h5C;
        ref_mem[8'h34] = 8'h5C;

        repeat (3) @(posedge aclk);
        #1;
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ack_err", 32'(ack_err), 32'd0);
        check("reset_scl", 32'(scl), 32'd1);
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;

        run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, 0, 1'b0);
        run_txn(1'b1, 7'h50, 8'h34, 8'h00, 1'b0, 0, 1'b0);
        run_txn(1'b0, 7'h50, 8'h56, 8'h99, 1'b1, 0, 1'b0);
        run_txn(1'b0, 7'h50, 8'h78, 8'h3C, 1'b0, 200, 1'b0);

        // reset during the data byte of a write
        @(posedge aclk); #1;
        rw = 1'b0; dev_addr = 7'h50; mem_addr = 8'h9A; wdata = 8'hE1; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (330) @(posedge aclk);
        #1;
        areset = 1'b1;
        #1;
        check("rst_mid_scl", 32'(scl), 32'd1);
        check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rdata", 32'(rdata), 32'd0);
        exp_rdata = 8'h00;
        @(posedge aclk); #1;
        areset = 1'b0;
        run_txn(1'b0, 7'h50, 8'h9A, 8'h6B, 1'b0, 0, 1'b0);

        // back-to-back: second start issued during the done cycle
        run_txn(1'b1, 7'h50, 8'h9A, 8'h00, 1'b0, 0, 1'b0);
        run_txn(1'b0, 7'h51, 8'h20, 8'h7E, 1'b0, 0, 1'b1);

        for (int k = 0; k < 6; k++)
            run_txn(1'($urandom), 7'($urandom), 8'($urandom_range(0, 7) * 32 + 8'h20), 8'($urandom),
                    ($urandom_range(0, 3) == 0), 0, 1'($urandom));
        run_txn(1'b1, 7'h50, 8'h20, 8'h00, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
